local_endpoint_ack_gen: RTL

- Terminates the switch's local output port (port 0): buffers packets the switch delivers to this router and classifies them.
- Data packets go to the local sink over a valid/ready handshake. For each one, an ACK packet is written into the switch's ACK FIFO (the writer for the switch's ACK-FIFO reader).
- Incoming ACK packets are reported on a one-cycle strobe.
- Misrouted packets and overflow drops are counted.

---
 rtl/local_endpoint_ack_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/local_endpoint_ack_gen.sv
// Local-port terminator: buffers switch deliveries, hands data packets to the
// local sink, emits one ACK per data packet, reports received ACKs, counts drops.
module local_endpoint_ack_gen #(
    parameter int ROUTER_WIDTH = 2,
    parameter int AURORA_WIDTH = 256,
    parameter int BUF_DEPTH    = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ROUTER_WIDTH-1:0] local_router,
    input  logic                    pkt_we,
    input  logic [AURORA_WIDTH-1:0] pkt_data,
    output logic                    sink_valid,
    output logic [AURORA_WIDTH-1:0] sink_data,
    input  logic                    sink_ready,
    input  logic                    ack_fifo_full,
    output logic                    we_ack_fifo,
    output logic [AURORA_WIDTH-1:0] ack_data_out,
    output logic                    ack_rx_valid,
    output logic [7:0]              ack_rx_seq,
    output logic [ROUTER_WIDTH-1:0] ack_rx_src,
    output logic                    buf_full,
    output logic [CNT_WIDTH-1:0]    drop_cnt,
    output logic [CNT_WIDTH-1:0]    misroute_cnt
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(BUF_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DELIVER,
        SEND_ACK
    } state_t;

    state_t                  state_q;
    logic [AURORA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W:0]          count_q;
    logic [PTR_W:0]          count_d;
    logic [AURORA_WIDTH-1:0] pkt_q;
    logic                    ack_rx_valid_q;
    logic [7:0]              ack_rx_seq_q;
    logic [ROUTER_WIDTH-1:0] ack_rx_src_q;
    logic [AURORA_WIDTH-1:0] ack_pkt;
    logic                    push;
    logic                    pop;
    logic                    misrouted;
    logic [1:0]              cnt_inc;

    // Acceptance is judged on the pre-pop count, so a write at full is lost
    // even when the FSM frees a slot in the same cycle.
    assign buf_full  = (count_q == DEPTH_C);
    assign push      = pkt_we && !buf_full;
    assign pop       = (state_q == LOAD);
    assign misrouted = (state_q == CHECK) && (pkt_q[3:2] != 2'(local_router));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pkt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pkt_q          <= '0;
            ack_rx_valid_q <= 1'b0;
            ack_rx_seq_q   <= '0;
            ack_rx_src_q   <= '0;
        end else begin
            ack_rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    pkt_q   <= mem[rd_ptr_q];
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (pkt_q[3:2] != 2'(local_router)) begin
                        state_q <= IDLE;
                    end else if (pkt_q[4]) begin
                        ack_rx_valid_q <= 1'b1;
                        ack_rx_seq_q   <= pkt_q[15:8];
                        ack_rx_src_q   <= ROUTER_WIDTH'(pkt_q[1:0]);
                        state_q        <= IDLE;
                    end else begin
                        state_q <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (sink_ready) begin
                        state_q <= SEND_ACK;
                    end
                end
                SEND_ACK: begin
                    if (!ack_fifo_full) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ack_pkt        = '0;
        ack_pkt[1:0]   = 2'(local_router);
        ack_pkt[3:2]   = pkt_q[1:0];
        ack_pkt[4]     = 1'b1;
        ack_pkt[15:8]  = pkt_q[15:8];
    end

    assign sink_valid   = (state_q == DELIVER);
    assign sink_data    = sink_valid ? pkt_q : '0;
    assign we_ack_fifo  = (state_q == SEND_ACK) && !ack_fifo_full;
    assign ack_data_out = (state_q == SEND_ACK) ? ack_pkt : '0;
    assign ack_rx_valid = ack_rx_valid_q;
    assign ack_rx_seq   = ack_rx_seq_q;
    assign ack_rx_src   = ack_rx_src_q;

    // Index 0 tracks overflow drops, index 1 tracks misroutes; both saturate.
    assign cnt_inc[0] = pkt_we && buf_full;
    assign cnt_inc[1] = misrouted;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (cnt_inc[gi] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign drop_cnt     = g_cnt[0].cnt_q;
    assign misroute_cnt = g_cnt[1].cnt_q;

endmodule
